usb_tx_ctrl: RTL

Transmit-side controller for the USB link: the counterpart to the receiver control unit.
- Sequences the serial transmit datapath for each packet: SYNC byte, data bytes pulled from the TX FIFO, EOP (2 bit times SE0 plus 1 bit time J), then idle.
- Contains the bit timer, bit/byte counters and load shift register. Drives the raw bit stream to the downstream NRZI encoder and line driver.

---
 rtl/usb_tx_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/usb_tx_ctrl.sv
// USB transmit control: SYNC, FIFO data bytes LSB first, EOP (SE0, SE0, J), then a one-cycle DONE.
// Define USB_BIT_STUFF_EN to insert a stuffed 0 after every six consecutive 1 bits.
module usb_tx_ctrl #(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_BYTES    = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_read,
  output logic       tx_bit,
  output logic       tx_eop,
  output logic       tx_enable,
  output logic       bit_tick,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);
  localparam int            TW       = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST_CLK = TW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    MAX_CNT  = 8'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_DATA, S_EOP_SE0, S_EOP_J, S_DONE
  } state_t;

  state_t        r_state, w_state_next;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_byte_cnt;
  logic [7:0]    r_shift;
  logic          r_overlong;

  logic w_active, w_serial, w_start;
  logic w_stuff_due, w_stuff_bit, w_advance, w_byte_end;

  assign w_active   = (r_state == S_SYNC) || (r_state == S_DATA) ||
                      (r_state == S_EOP_SE0) || (r_state == S_EOP_J);
  assign w_serial   = (r_state == S_SYNC) || (r_state == S_DATA);
  assign w_start    = (r_state == S_IDLE) && tx_start;
  assign bit_tick   = w_active && (r_timer == LAST_CLK);
  // A tick that starts a stuffed bit defers the bit advance to the end of that stuffed period.
  assign w_advance  = bit_tick && !w_stuff_due;
  assign w_byte_end = w_advance && w_serial && (r_bit_cnt == 3'd7);

`ifdef USB_BIT_STUFF_EN
  logic [2:0] r_ones;
  logic       r_stuff;

  assign w_stuff_bit = r_stuff;
  assign w_stuff_due = bit_tick && w_serial && !r_stuff && r_shift[0] && (r_ones == 3'd5);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ones  <= '0;
      r_stuff <= 1'b0;
    end else if (r_state == S_IDLE || w_state_next == S_EOP_SE0) begin
      r_ones  <= '0;
      r_stuff <= 1'b0;
    end else if (bit_tick && w_serial) begin
      if (r_stuff) begin
        r_stuff <= 1'b0;
        r_ones  <= '0;
      end else if (w_stuff_due) begin
        r_stuff <= 1'b1;
      end else begin
        r_ones <= r_shift[0] ? r_ones + 3'd1 : 3'd0;
      end
    end
  end
`else
  assign w_stuff_bit = 1'b0;
  assign w_stuff_due = 1'b0;
`endif

  // NOTE: state is updated with non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_overlong <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_timer <= (!w_active || bit_tick) ? '0 : r_timer + TW'(1);
      if (r_state == S_IDLE) begin
        r_bit_cnt <= '0;
        if (w_start) begin
          r_shift    <= 8'h80;
          r_byte_cnt <= '0;
          r_overlong <= 1'b0;
        end
      end else begin
        if (w_advance)
          r_bit_cnt <= (w_byte_end || w_state_next != r_state) ? 3'd0 : r_bit_cnt + 3'd1;
        if (w_advance && w_serial)
          r_shift <= fifo_read ? fifo_rdata : {1'b0, r_shift[7:1]};
        if (fifo_read)
          r_byte_cnt <= r_byte_cnt + 8'd1;
        if (w_byte_end && !fifo_empty && r_byte_cnt >= MAX_CNT)
          r_overlong <= 1'b1;
      end
    end
  end

  // NOTE: every output and the next state get a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    fifo_read    = 1'b0;
    tx_bit       = 1'b1;
    tx_eop       = 1'b0;
    tx_enable    = 1'b0;
    tx_busy      = 1'b0;
    tx_done      = 1'b0;
    tx_error     = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_state_next = S_SYNC;
      S_SYNC, S_DATA: begin
        tx_enable = 1'b1;
        tx_busy   = 1'b1;
        tx_bit    = r_shift[0] && !w_stuff_bit;
        if (w_byte_end) begin
          fifo_read    = !fifo_empty && (r_byte_cnt < MAX_CNT);
          w_state_next = fifo_read ? S_DATA : S_EOP_SE0;
        end
      end
      S_EOP_SE0: begin
        tx_enable = 1'b1;
        tx_busy   = 1'b1;
        tx_eop    = 1'b1;
        tx_bit    = 1'b0;
        if (w_advance && r_bit_cnt == 3'd1) w_state_next = S_EOP_J;
      end
      S_EOP_J: begin
        tx_enable = 1'b1;
        tx_busy   = 1'b1;
        if (w_advance) w_state_next = S_DONE;
      end
      S_DONE: begin
        tx_done      = 1'b1;
        tx_error     = (r_byte_cnt == 8'd0) || r_overlong;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end
endmodule
